// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: queues enter/exit pulses, tracks slot occupancy and
// entry time, charges a time-based fee on exit and sequences the two gates.

module parking_gate_ctrl #(
    parameter int SLOTS      = 16,
    parameter int MAX_CARS   = 16,
    parameter int TICK_DIV   = 100000000,
    parameter int TIME_W     = 16,
    parameter int RATE       = 2,
    parameter int FEE_W      = 16,
    parameter int GATE_CYC   = 50000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter,
    input  logic             exit,
    input  logic [3:0]       car_nb,
    input  logic             fee_ack,
    output logic             gate_in_open,
    output logic             gate_out_open,
    output logic [4:0]       occupancy,
    output logic             full,
    output logic [FEE_W-1:0] fee,
    output logic             fee_valid,
    output logic             err_evt,
    output logic             evt_drop,
    output logic             busy
);
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PRODW = TIME_W + FEE_W;
    localparam logic [4:0] OCC_MAX = 5'(MAX_CARS);

    typedef struct packed {
        logic       is_exit;
        logic [3:0] car;
    } evt_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_GATE_IN, S_FEE_CALC, S_WAIT_ACK, S_GATE_OUT
    } state_t;

    state_t state, state_nx;

    // ---------------- timebase ----------------
    logic [PW-1:0]     presc;
    logic [TIME_W-1:0] now_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            now_t <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
            now_t <= now_t + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ---------------- event FIFO ----------------
    evt_t          fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          one_evt, both_evt, push, pop;
    evt_t          in_evt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign one_evt    = enter ^ exit;
    assign both_evt   = enter & exit;
    // A full FIFO refuses the push even if the FSM pops in the same cycle.
    assign push       = one_evt & ~fifo_full;
    assign in_evt     = '{is_exit: exit, car: car_nb};

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= in_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            evt_drop <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            evt_drop <= both_evt | (one_evt & fifo_full);
        end
    end

    // ---------------- FSM ----------------
    evt_t                         cur;
    logic [SLOTS-1:0]             slot_map;
    logic [SLOTS-1:0][TIME_W-1:0] stamp;
    logic [GW-1:0]                gate_cnt;
    logic [TIME_W-1:0]            dur;
    logic                         slot_hit, gate_last;
    logic                         do_admit, do_release, do_err;

    assign slot_hit  = slot_map[cur.car];
    assign gate_last = (gate_cnt == GW'(GATE_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        do_admit   = 1'b0;
        do_release = 1'b0;
        do_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!cur.is_exit) begin
                    if (slot_hit || occupancy == OCC_MAX) begin
                        do_err   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        do_admit = 1'b1;
                        state_nx = S_GATE_IN;
                    end
                end else if (!slot_hit) begin
                    do_err   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    do_release = 1'b1;
                    state_nx   = S_FEE_CALC;
                end
            end
            S_GATE_IN:  if (gate_last) state_nx = S_IDLE;
            S_FEE_CALC: state_nx = S_WAIT_ACK;
            S_WAIT_ACK: if (fee_ack) state_nx = S_GATE_OUT;
            S_GATE_OUT: if (gate_last) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [PRODW-1:0] fee_prod;
    logic [FEE_W-1:0] fee_sat;

    // Product kept wide so any bit above FEE_W means saturation.
    assign fee_prod = PRODW'(dur) * PRODW'(RATE);
    assign fee_sat  = (|fee_prod[PRODW-1:FEE_W]) ? '1 : fee_prod[FEE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= '0;
            slot_map  <= '0;
            stamp     <= '0;
            occupancy <= '0;
            dur       <= '0;
            fee       <= '0;
            err_evt   <= 1'b0;
            gate_cnt  <= '0;
        end else begin
            err_evt <= do_err;
            if (pop)
                cur <= fifo_mem[rd_ptr[AW-1:0]];
            if (do_admit) begin
                slot_map[cur.car] <= 1'b1;
                stamp[cur.car]    <= now_t;
                occupancy         <= occupancy + 1'b1;
            end
            if (do_release) begin
                slot_map[cur.car] <= 1'b0;
                occupancy         <= occupancy - 1'b1;
                dur               <= now_t - stamp[cur.car];
            end
            if (state == S_FEE_CALC)
                fee <= fee_sat;
            if ((state == S_GATE_IN || state == S_GATE_OUT) && !gate_last)
                gate_cnt <= gate_cnt + 1'b1;
            else
                gate_cnt <= '0;
        end
    end

    assign gate_in_open  = (state == S_GATE_IN);
    assign gate_out_open = (state == S_GATE_OUT);
    assign fee_valid     = (state == S_WAIT_ACK);
    assign full          = (occupancy == OCC_MAX);
    assign busy          = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a short timebase and gate time.

module tb_parking_gate_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enter = 1'b0;
    logic        exit = 1'b0;
    logic [3:0]  car_nb = 4'd0;
    logic        fee_ack = 1'b0;
    logic        gate_in_open, gate_out_open, full, fee_valid, err_evt, evt_drop, busy;
    logic [4:0]  occupancy;
    logic [15:0] fee;

    int n_vec = 0;
    int n_err = 0;

    parking_gate_ctrl #(
        .SLOTS(16), .MAX_CARS(2), .TICK_DIV(4), .TIME_W(16), .RATE(2),
        .FEE_W(16), .GATE_CYC(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .enter(enter), .exit(exit), .car_nb(car_nb),
        .fee_ack(fee_ack), .gate_in_open(gate_in_open), .gate_out_open(gate_out_open),
        .occupancy(occupancy), .full(full), .fee(fee), .fee_valid(fee_valid),
        .err_evt(err_evt), .evt_drop(evt_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; enter = 1'b0; exit = 1'b0; fee_ack = 1'b0; car_nb = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic is_exit, input logic [3:0] car);
        enter = ~is_exit; exit = is_exit; car_nb = car;
        @(negedge clk);
        enter = 1'b0; exit = 1'b0;
    endtask

    // Drives n_evt back-to-back pulses from index 0 and records, per negedge
    // index, which outputs were high.
    task automatic window(input int n_evt, input logic is_exit, input logic [3:0] car0,
                          input logic inc, input int len,
                          output logic [31:0] gin, output logic [31:0] gout,
                          output logic [31:0] err, output logic [31:0] drop);
        gin = '0; gout = '0; err = '0; drop = '0;
        for (int i = 0; i < len; i++) begin
            if (i < n_evt) begin
                enter  = ~is_exit;
                exit   = is_exit;
                car_nb = inc ? car0 + 4'(i) : car0;
            end else begin
                enter = 1'b0;
                exit  = 1'b0;
            end
            gin[i]  = gate_in_open;
            gout[i] = gate_out_open;
            err[i]  = err_evt;
            drop[i] = evt_drop;
            @(negedge clk);
        end
        enter = 1'b0; exit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({gate_in_open, gate_out_open, full, fee_valid, err_evt, evt_drop, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {gate_in_open, gate_out_open, full, fee_valid, err_evt, evt_drop, busy});
        end
        n_vec++;
        if (occupancy !== 5'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_vec++;
        if (fee !== 16'd0) begin n_err++; $display("FAIL reset_fee: got %0d want 0", fee); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_collision();
        do_reset();
        enter = 1'b1; exit = 1'b1; car_nb = 4'd3;
        @(negedge clk);
        enter = 1'b0; exit = 1'b0;
        n_vec++;
        if (evt_drop !== 1'b1) begin n_err++; $display("FAIL coll_drop: got %b want 1", evt_drop); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL coll_busy: got %b want 0", busy); end
        @(negedge clk);
        n_vec++;
        if ({evt_drop, err_evt, busy} !== 3'b000) begin
            n_err++; $display("FAIL coll_after: got %b want 000", {evt_drop, err_evt, busy});
        end
    endtask

    task automatic test_enter();
        logic [31:0] gin, gout, err, drop;
        do_reset();
        window(1, 1'b0, 4'd5, 1'b0, 8, gin, gout, err, drop);
        n_vec++;
        if (gin !== 32'h38) begin n_err++; $display("FAIL enter_gate_in: got %h want %h", gin, 32'h38); end
        n_vec++;
        if ({gout, err, drop} !== 96'd0) begin
            n_err++; $display("FAIL enter_quiet: gout %h err %h drop %h want all 0", gout, err, drop);
        end
        n_vec++;
        if ({occupancy, full} !== {5'd1, 1'b0}) begin
            n_err++; $display("FAIL enter_occ: got occ %0d full %b want 1 0", occupancy, full);
        end
    endtask

    task automatic test_fee();
        logic [2:0] pat;
        do_reset();
        fee_ack = 1'b1;
        @(negedge clk);
        fee_ack = 1'b0;
        n_vec++;
        if ({busy, gate_out_open} !== 2'b00) begin
            n_err++; $display("FAIL fee_idle_ack: got busy/gout %b want 00", {busy, gate_out_open});
        end
        pulse(1'b0, 4'd5);
        repeat (39) @(negedge clk);
        pulse(1'b1, 4'd5);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (fee_valid !== 1'b0) begin n_err++; $display("FAIL fee_early: got %b want 0", fee_valid); end
        fee_ack = 1'b1;
        @(negedge clk);
        fee_ack = 1'b0;
        n_vec++;
        if ({fee_valid, fee} !== {1'b1, 16'd20}) begin
            n_err++; $display("FAIL fee_value: got valid %b fee %0d want 1 20", fee_valid, fee);
        end
        n_vec++;
        if (occupancy !== 5'd0) begin n_err++; $display("FAIL fee_occ: got %0d want 0", occupancy); end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({fee_valid, gate_out_open, fee} !== {2'b10, 16'd20}) begin
            n_err++; $display("FAIL fee_hold: got valid %b gout %b fee %0d want 1 0 20",
                              fee_valid, gate_out_open, fee);
        end
        fee_ack = 1'b1;
        @(negedge clk);
        fee_ack = 1'b0;
        n_vec++;
        if ({fee_valid, gate_out_open, gate_in_open} !== 3'b010) begin
            n_err++; $display("FAIL fee_ack_gate: got valid/gout/gin %b want 010",
                              {fee_valid, gate_out_open, gate_in_open});
        end
        pat = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pat = {pat[1:0], gate_out_open};
        end
        n_vec++;
        if (pat !== 3'b110) begin n_err++; $display("FAIL fee_gate_out_len: got %b want 110", pat); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL fee_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_full();
        logic [31:0] gin, gout, err, drop;
        do_reset();
        window(3, 1'b0, 4'd1, 1'b1, 24, gin, gout, err, drop);
        n_vec++;
        if (gin !== 32'h738) begin n_err++; $display("FAIL full_gate_in: got %h want %h", gin, 32'h738); end
        n_vec++;
        if (err !== 32'h2000) begin n_err++; $display("FAIL full_err: got %h want %h", err, 32'h2000); end
        n_vec++;
        if ({gout, drop} !== 64'd0) begin
            n_err++; $display("FAIL full_quiet: gout %h drop %h want 0", gout, drop);
        end
        n_vec++;
        if ({occupancy, full} !== {5'd2, 1'b1}) begin
            n_err++; $display("FAIL full_occ: got occ %0d full %b want 2 1", occupancy, full);
        end
    endtask

    task automatic test_errors();
        logic [31:0] gin, gout, err, drop;
        do_reset();
        window(1, 1'b1, 4'd7, 1'b0, 8, gin, gout, err, drop);
        n_vec++;
        if (err !== 32'h8) begin n_err++; $display("FAIL empty_exit_err: got %h want %h", err, 32'h8); end
        n_vec++;
        if ({gin, gout, occupancy} !== {64'd0, 5'd0}) begin
            n_err++; $display("FAIL empty_exit_quiet: gin %h gout %h occ %0d want 0", gin, gout, occupancy);
        end
        window(2, 1'b0, 4'd4, 1'b0, 14, gin, gout, err, drop);
        n_vec++;
        if (gin !== 32'h38) begin n_err++; $display("FAIL dup_gate_in: got %h want %h", gin, 32'h38); end
        n_vec++;
        if (err !== 32'h100) begin n_err++; $display("FAIL dup_err: got %h want %h", err, 32'h100); end
        n_vec++;
        if (occupancy !== 5'd1) begin n_err++; $display("FAIL dup_occ: got %0d want 1", occupancy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] gin, gout, err, drop;
        do_reset();
        window(7, 1'b0, 4'd0, 1'b1, 26, gin, gout, err, drop);
        n_vec++;
        if (drop !== 32'hC0) begin n_err++; $display("FAIL b2b_drop: got %h want %h", drop, 32'hC0); end
        n_vec++;
        if (err !== 32'h2A000) begin n_err++; $display("FAIL b2b_err: got %h want %h", err, 32'h2A000); end
        n_vec++;
        if (gin !== 32'h738) begin n_err++; $display("FAIL b2b_gate_in: got %h want %h", gin, 32'h738); end
        n_vec++;
        if (gout !== 32'h0) begin n_err++; $display("FAIL b2b_gate_out: got %h want 0", gout); end
        n_vec++;
        if ({occupancy, full, busy} !== {5'd2, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL b2b_occ: got occ %0d full %b busy %b want 2 1 0", occupancy, full, busy);
        end
        // Car 1 was the one admitted, so exiting 2 fails and exiting 1 bills.
        window(1, 1'b1, 4'd2, 1'b0, 6, gin, gout, err, drop);
        n_vec++;
        if (err !== 32'h8) begin n_err++; $display("FAIL b2b_exit2_err: got %h want %h", err, 32'h8); end
        window(1, 1'b1, 4'd1, 1'b0, 6, gin, gout, err, drop);
        n_vec++;
        if ({fee_valid, err, occupancy} !== {1'b1, 32'd0, 5'd1}) begin
            n_err++; $display("FAIL b2b_exit1: got valid %b err %h occ %0d want 1 0 1", fee_valid, err, occupancy);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [31:0] gin, gout, err, drop;
        int k;
        do_reset();
        pulse(1'b0, 4'd9);
        repeat (11) @(negedge clk);
        pulse(1'b1, 4'd9);
        k = 0;
        while (fee_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if ({fee_valid, fee} !== {1'b1, 16'd6}) begin
            n_err++; $display("FAIL mid_fee: got valid %b fee %0d want 1 6", fee_valid, fee);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({fee_valid, gate_in_open, gate_out_open, busy, occupancy, fee} !== 25'd0) begin
            n_err++; $display("FAIL mid_async_rst: got valid %b gin %b gout %b busy %b occ %0d fee %0d want all 0",
                              fee_valid, gate_in_open, gate_out_open, busy, occupancy, fee);
        end
        @(negedge clk);
        rst = 1'b0;
        window(1, 1'b1, 4'd9, 1'b0, 6, gin, gout, err, drop);
        n_vec++;
        if (err !== 32'h8) begin n_err++; $display("FAIL mid_exit_err: got %h want %h", err, 32'h8); end
        n_vec++;
        if ({fee_valid, gout, occupancy} !== {1'b0, 32'd0, 5'd0}) begin
            n_err++; $display("FAIL mid_exit_quiet: got valid %b gout %h occ %0d want 0", fee_valid, gout, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_enter();
        test_fee();
        test_full();
        test_errors();
        test_back_to_back();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
